mesm6_bus_arbiter: RTL
======================

MESM6_BUS_ARBITER -- requirements
Module: mesm6_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, range 2..65535: bus cycles allowed per transaction before a forced abort (used only with MESM6_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 if_addr  input  15  instruction-fetch word address.
REQ-005 if_read  input  1  fetch read request, level, held until if_done.
REQ-006 if_rdata  output  48  fetch read data, valid while if_done=1.
REQ-007 if_done  output  1  fetch completion, one-cycle pulse.
REQ-008 d_addr  input  15  data-port word address.
REQ-009 d_read  input  1  data read request, level, held until d_done.
REQ-010 d_write  input  1  data write request, level, held until d_done.
REQ-011 d_wdata  input  48  data write word.
REQ-012 d_rdata  output  48  data read word, valid while d_done=1.
REQ-013 d_done  output  1  data completion, one-cycle pulse.
REQ-014 bus_addr, bus_read, bus_write, bus_wdata  output  15/1/1/48  shared bus towards the memory mapper.
REQ-015 bus_rdata, bus_done  input  48/1  shared bus read data and completion.
REQ-016 bus_err  output  1  one-cycle pulse on a timeout abort.
REQ-017 bus_owner  output  1  0=fetch, 1=data; owner of the current or most recent grant.

Function
REQ-018 FSM states: IDLE, BUSY_IF, BUSY_D; BUSY_IF and BUSY_D are entered only from IDLE.
REQ-019 IDLE with exactly one requester active: grant it; with both active: grant the port not served last (round-robin).
REQ-020 On grant, capture address, write data and operation into registers; state becomes BUSY_* on the next edge.
REQ-021 bus_read/bus_write SHALL be driven only from the captured operation, and only in BUSY_*: request sampled in cycle N gives a bus strobe in cycle N+1.
REQ-022 Data port with d_read and d_write both high: operation is a write; the read is ignored.
REQ-023 In BUSY_*, bus_done=1: pulse the owner's done in the same cycle; owner's rdata = bus_rdata (combinational); return to IDLE on that edge.
REQ-024 The non-owner's done SHALL remain 0; the non-owner's rdata SHALL be 0.
REQ-025 Requesters SHALL drop their request in the cycle after done; a request seen in IDLE is a new transaction.
REQ-026 bus_done while in IDLE SHALL be ignored.
REQ-027 bus_owner updates on each grant and holds in IDLE; last-served flag = bus_owner.
REQ-028 Captured registers SHALL be stable throughout BUSY_*, regardless of the requester inputs.

Reset
REQ-029 reset_n low: state IDLE; bus_read, bus_write, if_done, d_done and bus_err all 0; bus_addr and bus_wdata 0; bus_owner 1 (fetch wins the first contention); timeout counter 0.
REQ-030 Reset mid-transaction SHALL drop the strobes immediately (asynchronously); no done pulse is issued for the aborted transaction.

Configuration
REQ-031 Macro MESM6_ARB_TIMEOUT_EN defined: a counter clears on grant and increments every cycle in BUSY_*.
REQ-032 With the macro defined, when the count reaches TIMEOUT_CYCLES-1 without bus_done: pulse the owner's done with rdata=0, pulse bus_err, drop the strobes and go to IDLE.
REQ-033 With the macro defined, bus_done arriving in the timeout cycle wins: normal completion, no bus_err.
REQ-034 Macro undefined: no counter; BUSY_* waits indefinitely for bus_done; bus_err is tied to 0.

Structure
REQ-035 The state enum arb_state_t and the default timeout constant SHALL live in the shared MESM-6 defines package; port widths SHALL use the existing address and word-size constants.
REQ-036 The timeout counter SHALL be the sole sub-module, mesm6_arb_timeout (ports: clk, reset_n, clear, run, expired), instantiated only under MESM6_ARB_TIMEOUT_EN.

Verification
REQ-037 Single fetch: if_read, if_addr=15'o01234, with bus_done arriving 3 cycles after the strobe and bus_rdata=48'h123456789ABC -> bus_read high from cycle N+1; if_done one cycle; if_rdata=48'h123456789ABC; d_done stays 0.
REQ-038 Contention after reset: if_read and d_write raised in the same cycle -> fetch served first (bus_owner=0); data served next with bus_write=1 and bus_wdata=d_wdata; both requests held continuously -> grants alternate fetch, data, fetch.
REQ-039 d_read and d_write both high, d_addr=15'o00010 -> bus_write=1, bus_read=0.
REQ-040 MESM6_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and bus_done never asserted -> d_done and bus_err pulse together in the 8th BUSY cycle, d_rdata=0; a bus_done arriving later is ignored.
REQ-041 reset_n pulsed low during BUSY_D -> bus_write falls without waiting for a clock edge; no d_done; after release, state IDLE and bus_owner=1.

Source files
------------

// File: rtl/mesm6_bus_arbiter_pkg.sv
// mesm6_bus_arbiter_pkg: shared MESM-6 defines for the bus arbiter (widths, states, timeout default).
package mesm6_bus_arbiter_pkg;
  localparam int ADDR_W = 15;
  localparam int WORD_W = 48;
  localparam int ARB_TIMEOUT_DEFAULT = 256;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} arb_state_t;
endpackage

// File: rtl/mesm6_bus_arbiter_if.sv
// mesm6_bus_arbiter_if: fetch port, data port and shared memory bus; master = arbiter view.
interface mesm6_bus_arbiter_if;
  import mesm6_bus_arbiter_pkg::*;
  logic [ADDR_W-1:0] if_addr;
  logic              if_read;
  logic [WORD_W-1:0] if_rdata;
  logic              if_done;
  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [WORD_W-1:0] d_wdata;
  logic [WORD_W-1:0] d_rdata;
  logic              d_done;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_read;
  logic              bus_write;
  logic [WORD_W-1:0] bus_wdata;
  logic [WORD_W-1:0] bus_rdata;
  logic              bus_done;
  logic              bus_err;
  logic              bus_owner;
  modport master (
    input  if_addr, if_read, d_addr, d_read, d_write, d_wdata, bus_rdata, bus_done,
    output if_rdata, if_done, d_rdata, d_done, bus_addr, bus_read, bus_write, bus_wdata,
           bus_err, bus_owner
  );
  modport slave (
    output if_addr, if_read, d_addr, d_read, d_write, d_wdata, bus_rdata, bus_done,
    input  if_rdata, if_done, d_rdata, d_done, bus_addr, bus_read, bus_write, bus_wdata,
           bus_err, bus_owner
  );
endinterface

// File: rtl/mesm6_arb_timeout.sv
// mesm6_arb_timeout: per-transaction cycle counter; expired flags the last allowed busy cycle.
module mesm6_arb_timeout
  import mesm6_bus_arbiter_pkg::*;
#(
  parameter int CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= cnt + 16'd1;
  assign expired = run && cnt == 16'(CYCLES - 1);
endmodule

// File: rtl/mesm6_bus_arbiter.sv
// mesm6_bus_arbiter: round-robin arbiter of fetch and data ports onto one memory bus.
// Optional transaction timeout abort enabled by defining MESM6_ARB_TIMEOUT_EN.
module mesm6_bus_arbiter
  import mesm6_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  mesm6_bus_arbiter_if.master ifc
);
  arb_state_t state;
  logic d_req, grant_if, grant_d, busy, expired, finish;
  assign d_req    = ifc.d_read || ifc.d_write;
  // bus_owner doubles as the last-served flag: fetch wins unless it was served last
  assign grant_if = state == IDLE && ifc.if_read && (!d_req || ifc.bus_owner);
  assign grant_d  = state == IDLE && d_req && !grant_if;
  assign busy     = state != IDLE;
  assign finish   = busy && (ifc.bus_done || expired);
  assign ifc.if_done  = finish && state == BUSY_IF;
  assign ifc.d_done   = finish && state == BUSY_D;
  assign ifc.if_rdata = (state == BUSY_IF && ifc.bus_done) ? ifc.bus_rdata : '0;
  assign ifc.d_rdata  = (state == BUSY_D && ifc.bus_done) ? ifc.bus_rdata : '0;
`ifdef MESM6_ARB_TIMEOUT_EN
  mesm6_arb_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .reset_n(reset_n), .clear(grant_if || grant_d), .run(busy), .expired(expired)
  );
  assign ifc.bus_err = expired && !ifc.bus_done;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expired     = 1'b0;
  assign ifc.bus_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= IDLE;
      ifc.bus_read  <= 1'b0;
      ifc.bus_write <= 1'b0;
      ifc.bus_addr  <= '0;
      ifc.bus_wdata <= '0;
      ifc.bus_owner <= 1'b1;
    end else if (grant_if || grant_d) begin
      state         <= grant_if ? BUSY_IF : BUSY_D;
      ifc.bus_owner <= grant_d;
      ifc.bus_addr  <= grant_if ? ifc.if_addr : ifc.d_addr;
      ifc.bus_wdata <= grant_d ? ifc.d_wdata : '0;
      ifc.bus_read  <= grant_if || !ifc.d_write;
      ifc.bus_write <= grant_d && ifc.d_write;
    end else if (finish) begin
      state         <= IDLE;
      ifc.bus_read  <= 1'b0;
      ifc.bus_write <= 1'b0;
    end
endmodule
